// File: rtl/dm_defs_pkg.sv
// ---------------------------------------------------------------------------
// dm_defs : shared definitions for the data-memory responder.
//   - FSM state encoding (IDLE/WAIT/DONE)
//   - operation encoding (OP_RD/OP_WR)
//   - widths used by the request error check
//   - req_bad(): misaligned / out-of-range / conflicting-strobe check
// ---------------------------------------------------------------------------
package dm_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BYTE_OFF_W = 2;   // byte offset bits inside a 32-bit word
   localparam int CNT_W      = 4;   // wait counter, covers 0..15 wait states

   // A request is bad if it is not word aligned, falls beyond the last
   // stored word, or asks for a read and a write at the same time.
   function automatic logic req_bad(input logic              rd,
                                    input logic              wr,
                                    input logic [ADDR_W-1:0] addr,
                                    input int                idx_w);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[BYTE_OFF_W-1:0] != '0);
      out_of_range = ((addr >> (idx_w + BYTE_OFF_W)) != '0);
      return misaligned || out_of_range || (rd && wr);
   endfunction

endpackage

// File: rtl/dm_storage.sv
// ---------------------------------------------------------------------------
// dm_storage : DEPTH_WORDS x 32 word array.
//   CLK, RESET      : clock, synchronous active-high clear of every word
//   we, widx, wdata : synchronous write port
//   ridx, rdata     : combinational read port (returns pre-write contents)
// ---------------------------------------------------------------------------
module dm_storage
   import dm_defs::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[widx] <= wdata;
      end
   end

   assign rdata = mem_q[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder : memory end of the datapath's data-memory interface.
// Accepts one read/write strobe, waits WAIT_STATES cycles, then pulses
// ready for one cycle (with error on a bad request).
//   CLK, RESET              : clock, synchronous active-high reset
//   C_read_dm, C_write_dm   : request strobes, held by requester until ready
//   addr, data_write_dm     : byte address and write data
//   data_read_dm            : last successful read data (held)
//   ready, error            : one-cycle completion / error pulse
//   busy                    : request in flight (WAIT or DONE)
// ---------------------------------------------------------------------------
module data_mem_responder
   import dm_defs::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              C_read_dm,
   input  logic              C_write_dm,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_write_dm,
   output logic [DATA_W-1:0] data_read_dm,
   output logic              ready,
   output logic              error,
   output logic              busy
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CNT_INIT_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   op_e               op_q, op_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              busy_q, busy_d;

   logic              enter_done;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      error_d    = 1'b0;
      enter_done = 1'b0;
      mem_we     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (C_read_dm || C_write_dm) begin
               op_d    = C_write_dm ? OP_WR : OP_RD;
               idx_d   = addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
               wdata_d = data_write_dm;
               err_d   = req_bad(C_read_dm, C_write_dm, addr, IDX_W);
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  state_d    = DONE;
                  enter_done = 1'b1;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d    = DONE;
               enter_done = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Commit on the edge entering DONE. The *_d copies are used so the
      // zero-wait path (latch and commit on one edge) works the same way.
      if (enter_done) begin
         ready_d = 1'b1;
         error_d = err_d;
         if (!err_d) begin
            if (op_d == OP_WR) mem_we  = 1'b1;
            else               rdata_d = mem_rdata;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_RD;
         idx_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
         busy_q  <= busy_d;
      end
   end

   dm_storage #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_storage (
      .CLK   (CLK),
      .RESET (RESET),
      .we    (mem_we),
      .widx  (idx_d),
      .wdata (wdata_d),
      .ridx  (idx_d),
      .rdata (mem_rdata)
   );

   assign data_read_dm = rdata_q;
   assign ready        = ready_q;
   assign error        = error_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder : two responders (WAIT_STATES=2 and 0) driven by
// directed and random accesses, checked against an array model of memory.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        rd   [2];
   logic        wr   [2];
   logic [31:0] ad   [2];
   logic [31:0] wd   [2];
   logic [31:0] rdat [2];
   logic        rdy  [2];
   logic        er   [2];
   logic        bsy  [2];

   always #5 CLK = ~CLK;

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut2 (
      .CLK(CLK), .RESET(RESET), .C_read_dm(rd[0]), .C_write_dm(wr[0]),
      .addr(ad[0]), .data_write_dm(wd[0]), .data_read_dm(rdat[0]),
      .ready(rdy[0]), .error(er[0]), .busy(bsy[0]));

   data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
      .CLK(CLK), .RESET(RESET), .C_read_dm(rd[1]), .C_write_dm(wr[1]),
      .addr(ad[1]), .data_write_dm(wd[1]), .data_read_dm(rdat[1]),
      .ready(rdy[1]), .error(er[1]), .busy(bsy[1]));

   // reference model
   logic [31:0] mem    [2][256];
   logic [31:0] exp_rd [2];
   int          total = 0;
   int          bad   = 0;

   function automatic int ws_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) mem[d][i] = '0;
         exp_rd[d] = '0;
      end
   endtask

   // One full access: present strobes, wait for ready, drop strobes on ready.
   task automatic access(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] v, input string tag);
      logic e;
      int   n, bc;
      bit   got;
      @(negedge CLK);
      rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = v;
      e = (a[1:0] != 2'd0) || (a >= 32'd1024) || (r && w);
      if (!e && w)      mem[d][a[9:2]] = v;
      else if (!e && r) exp_rd[d] = mem[d][a[9:2]];
      n = 0; bc = 0; got = 0;
      while (!got && n < 40) begin
         @(negedge CLK);
         n++;
         if (bsy[d]) bc++;
         if (rdy[d]) begin
            got = 1;
            rd[d] = 1'b0; wr[d] = 1'b0;
         end
      end
      chk({tag, " ready_seen"}, 32'(got), 32'd1);
      if (got) begin
         chk({tag, " latency"}, 32'(n), 32'(ws_of(d) + 1));
         chk({tag, " busy_cycles"}, 32'(bc), 32'(ws_of(d) + 1));
         chk({tag, " error"}, 32'(er[d]), 32'(e));
         chk({tag, " rdata"}, rdat[d], exp_rd[d]);
      end
   endtask

   initial begin
      int          n, pulses, last, rc, sel, k;
      logic [31:0] a, v;
      logic        r, w;

      RESET = 1'b1;
      for (int d = 0; d < 2; d++) begin
         rd[d] = 0; wr[d] = 0; ad[d] = '0; wd[d] = '0;
      end
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset ready%0d", d), 32'(rdy[d]), 32'd0);
         chk($sformatf("reset error%0d", d), 32'(er[d]), 32'd0);
         chk($sformatf("reset busy%0d", d), 32'(bsy[d]), 32'd0);
         chk($sformatf("reset rdata%0d", d), rdat[d], 32'd0);
      end

      // directed, WAIT_STATES=2
      access(0, 1, 0, 32'h10,  32'h0,        "rd10");
      access(0, 0, 1, 32'h20,  32'hDEADBEEF, "wr20");
      access(0, 1, 0, 32'h20,  32'h0,        "rd20");
      access(0, 1, 0, 32'h22,  32'h0,        "rd_misaligned");
      access(0, 0, 1, 32'h400, 32'h11112222, "wr_oor");
      access(0, 1, 0, 32'h0,   32'h0,        "rd0");
      access(0, 1, 1, 32'h20,  32'h55555555, "both_strobes");
      access(0, 1, 0, 32'h3FC, 32'h0,        "rd_last_word");

      // directed, WAIT_STATES=0
      access(1, 0, 1, 32'h4,   32'h12345678, "ws0_wr4");
      access(1, 1, 0, 32'h4,   32'h0,        "ws0_rd4");
      access(1, 0, 1, 32'h3FC, 32'hA5A5A5A5, "ws0_wr_last");
      access(1, 1, 0, 32'h3FC, 32'h0,        "ws0_rd_last");
      access(1, 1, 0, 32'h400, 32'h0,        "ws0_rd_oor");

      // random accesses on both responders
      for (int i = 0; i < 24; i++) begin
         for (int d = 0; d < 2; d++) begin
            sel = $urandom_range(0, 9);
            a   = 32'($urandom_range(0, 15)) << 2;
            if (sel == 0) a = a | 32'($urandom_range(1, 3));
            if (sel == 1) a = 32'h400 + (32'($urandom_range(0, 255)) << 2);
            if (sel == 2) a = $urandom | 32'h8000_0000;
            k = $urandom_range(0, 9);
            r = (k < 4) || (k == 9);
            w = (k >= 4);
            v = $urandom;
            access(d, r, w, a, v, $sformatf("rand%0d_d%0d", i, d));
         end
      end

      // strobe held across ready on the 2-wait-state responder; junk on the
      // other inputs during WAIT must not change the returned data
      @(negedge CLK);
      rd[0] = 1'b1; wr[0] = 1'b0; ad[0] = 32'h20; wd[0] = $urandom;
      exp_rd[0] = mem[0][8];
      n = 0; pulses = 0; last = 0;
      while (pulses < 3 && n < 30) begin
         @(negedge CLK);
         n++;
         if (rdy[0]) begin
            pulses++;
            chk($sformatf("held pulse%0d spacing", pulses), 32'(n - last),
                (pulses == 1) ? 32'd3 : 32'd4);
            chk($sformatf("held pulse%0d rdata", pulses), rdat[0], exp_rd[0]);
            chk($sformatf("held pulse%0d error", pulses), 32'(er[0]), 32'd0);
            last = n;
            wr[0] = 1'b0; ad[0] = 32'h20;
            if (pulses == 3) rd[0] = 1'b0;
         end else if (bsy[0]) begin
            ad[0] = $urandom; wd[0] = $urandom; wr[0] = 1'($urandom_range(0, 1));
         end else begin
            wr[0] = 1'b0; ad[0] = 32'h20;
         end
      end
      chk("held pulse_count", 32'(pulses), 32'd3);
      @(negedge CLK);
      chk("held idle_after", 32'(bsy[0]), 32'd0);

      // reset during WAIT aborts the write and suppresses ready
      @(negedge CLK);
      wr[0] = 1'b1; rd[0] = 1'b0; ad[0] = 32'h8; wd[0] = 32'hCAFEF00D;
      @(negedge CLK);
      chk("midrst busy_in_wait", 32'(bsy[0]), 32'd1);
      RESET = 1'b1; wr[0] = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      model_reset();
      chk("midrst busy", 32'(bsy[0]), 32'd0);
      chk("midrst ready", 32'(rdy[0]), 32'd0);
      rc = 0;
      repeat (6) begin
         @(negedge CLK);
         if (rdy[0]) rc++;
      end
      chk("midrst no_ready", 32'(rc), 32'd0);
      access(0, 1, 0, 32'h8, 32'h0, "midrst rd8");
      access(1, 1, 0, 32'h4, 32'h0, "midrst ws0_rd4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
